cmp_search: RTL and testbench



---
 rtl/cmp_search.sv | 112 +++++++++++
 tb/tb_cmp_search.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_search.sv
// Binary-search controller for an external combinational magnitude comparator.
// Drives the A operand (probe) and narrows [lo, hi] on the one-hot relation result.
module cmp_search #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  input  logic [2:0]       rel_in,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  // Handshake: start is a level sampled only in IDLE; busy covers PROBE and DONE,
  // done is a one-cycle pulse, and found/err/result hold until the next accepted start.
  typedef enum logic [1:0] {IDLE = 2'd0, PROBE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WIDTH-1:0] FIRST_PROBE = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH:0]   ONE_W1      = {{WIDTH{1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] lo, hi;
  logic [WIDTH:0]   sum_up, sum_dn;
  logic [WIDTH-1:0] mid_up, mid_dn;
  logic             one_hot;

  // Next midpoints for the two narrowing directions, summed at WIDTH+1 bits.
  // sum_dn is only used when probe != lo, so probe-1 never underflows there.
  always_comb begin
    sum_up  = {1'b0, probe} + ONE_W1 + {1'b0, hi};
    sum_dn  = {1'b0, lo} + {1'b0, probe} - ONE_W1;
    mid_up  = sum_up[WIDTH:1];
    mid_dn  = sum_dn[WIDTH:1];
    one_hot = (rel_in == 3'b001) || (rel_in == 3'b010) || (rel_in == 3'b100);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      probe  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lo     <= '0;
            hi     <= '1;
            probe  <= FIRST_PROBE;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            busy   <= 1'b1;
            state  <= PROBE;
          end
        end

        PROBE: begin
          if (!one_hot) begin
            err   <= 1'b1;
            found <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (rel_in[1]) begin
            found  <= 1'b1;
            result <= probe;
            done   <= 1'b1;
            state  <= DONE;
          end else if (rel_in[0]) begin
            if (probe == hi) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              lo    <= probe + 1'b1;
              probe <= mid_up;
            end
          end else begin
            if (probe == lo) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              hi    <= probe - 1'b1;
              probe <= mid_dn;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_search.sv
// Bench for cmp_search: directed and random B values against a reference
// binary search computed with plain integer arithmetic.
module tb_cmp_search;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] probe;
  logic [2:0]   rel_in;
  logic         busy, done, found, err;
  logic [W-1:0] result;

  int           b_val;
  bit           all_gt;
  bit           bad_now;

  int           checks = 0;
  int           errors = 0;

  logic [W-1:0] exp_q[$];
  int           exp_k;
  bit           exp_found, exp_err;
  int           exp_result;

  cmp_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .probe  (probe),
    .rel_in (rel_in),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // comparator model: combinational from probe, with fault injection hooks
  always_comb begin
    rel_in = 3'b000;
    if (bad_now)
      rel_in = 3'b011;
    else if (all_gt)
      rel_in = 3'b100;
    else if (int'(probe) < b_val)
      rel_in = 3'b001;
    else if (int'(probe) == b_val)
      rel_in = 3'b010;
    else
      rel_in = 3'b100;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference: search the value range for b, recording each probe value
  task automatic model(input int b, input bit gt_only, input int bad_at);
    int lo, hi, mid, n;
    exp_q.delete();
    exp_found  = 0;
    exp_err    = 0;
    exp_result = 0;
    lo = 0;
    hi = (1 << W) - 1;
    n  = 0;
    while (n < 2 * W) begin
      mid = (lo + hi) / 2;
      exp_q.push_back(mid[W-1:0]);
      n++;
      if (n == bad_at) begin
        exp_err = 1;
        break;
      end
      if (!gt_only && mid == b) begin
        exp_found  = 1;
        exp_result = mid;
        break;
      end
      if (!gt_only && mid < b) begin
        if (mid == hi) break;
        lo = mid + 1;
      end else begin
        if (mid == lo) break;
        hi = mid - 1;
      end
    end
    exp_k = n;
  endtask

  // drive one full search from IDLE; called on a negedge, returns on a negedge in IDLE
  task automatic run_search(input int b, input bit gt_only, input int bad_at,
                            input bit hold_start);
    logic [W-1:0] last;
    model(b, gt_only, bad_at);
    b_val  = b;
    all_gt = gt_only;
    start  = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    chk("cleared_found", found, 0);
    chk("cleared_err", err, 0);
    chk("cleared_result", result, 0);
    for (int i = 1; i <= exp_k; i++) begin
      last = exp_q.pop_front();
      chk($sformatf("probe_b%0d_i%0d", b, i), probe, last);
      chk("busy_probe", busy, 1);
      chk("done_probe", done, 0);
      bad_now = (i == bad_at);
      @(negedge clk);
      bad_now = 1'b0;
    end
    chk($sformatf("done_b%0d", b), done, 1);
    chk("busy_done", busy, 1);
    chk($sformatf("found_b%0d", b), found, exp_found);
    chk($sformatf("err_b%0d", b), err, exp_err);
    chk($sformatf("result_b%0d", b), result, exp_result);
    start = 1'b0;
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("busy_idle", busy, 0);
    chk("probe_hold", probe, last);
    chk("found_hold", found, exp_found);
    chk("result_hold", result, exp_result);
  endtask

  initial begin
    logic [W-1:0] p;
    rst_n   = 1'b0;
    start   = 1'b0;
    b_val   = 0;
    all_gt  = 1'b0;
    bad_now = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_probe", probe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // directed boundary searches
    run_search(127, 1'b0, 0, 1'b0);
    run_search(0,   1'b0, 0, 1'b0);
    run_search(255, 1'b0, 0, 1'b0);
    run_search(77,  1'b0, 2, 1'b0);
    run_search(200, 1'b0, 0, 1'b0);
    run_search(0,   1'b1, 0, 1'b0);
    run_search(128, 1'b0, 0, 1'b0);

    // randomized B values, some with a malformed relation on a random probe
    for (int n = 0; n < 30; n++) begin
      int b, bad;
      b   = $urandom_range(0, 255);
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      run_search(b, 1'b0, bad, $urandom_range(0, 1) == 1);
    end

    // reset during the fourth probe with start held high throughout
    model(37, 1'b0, 0);
    b_val  = 37;
    all_gt = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      p = exp_q.pop_front();
      chk($sformatf("rstrun_probe_i%0d", i), probe, p);
      @(negedge clk);
    end
    p = exp_q.pop_front();
    chk("rstrun_probe_i4", probe, p);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    chk("midrst_probe", probe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_found", found, 0);
    chk("midrst_err", err, 0);
    chk("midrst_result", result, 0);
    @(negedge clk);
    chk("midrst_no_done", done, 0);
    chk("midrst_idle", busy, 0);
    run_search(90, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
